mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access unit: consumes the memory-operation fields presented by the EX/MEM pipeline register and turns each load or store into a req/ack transaction on the data bus. It holds the pipeline with `stall_mem` while a transaction is outstanding, then delivers the result to the MEM/WB register. Non-memory instructions pass straight through with no added latency.

## Interface

- `DATA_W`, 32: data width (matches the data bus).
- `ADDR_W`, 32: address width.
- `REG_W`, 5: register-address width.
- `TIMEOUT`, 16: maximum REQ cycles without an ack before abort; 0 disables the timeout; legal range 0..255.

Ports:

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `data_in` in DATA_W: ALU result from EX/MEM.
- `reg_write_en_in` in 1: writeback enable from EX/MEM.
- `reg_addr_in` in REG_W: destination register.
- `mem_read_flag_in` in 1: load instruction.
- `mem_write_flag_in` in 1: store instruction.
- `mem_addr_in` in ADDR_W: effective address.
- `mem_write_data_in` in DATA_W: store data.
- `data_out` out DATA_W: value to MEM/WB.
- `reg_write_en_out` out 1: writeback enable to MEM/WB.
- `reg_addr_out` out REG_W: destination register to MEM/WB.
- `stall_mem` out 1: stall request to the pipeline stall controller.
- `bus_req` out 1: data-bus request (registered).
- `bus_we` out 1: 1 = write (registered).
- `bus_addr` out ADDR_W: word-aligned address {addr[ADDR_W-1:2],2'b00} (registered).
- `bus_wdata` out DATA_W: store data (registered).
- `bus_rdata` in DATA_W: read data, valid when `bus_ack` is high.
- `bus_ack` in 1: one-cycle completion strobe.
- `bus_timeout` out 1: one-cycle pulse marking an aborted transaction (registered).

## Operation

- `op = mem_read_flag_in | mem_write_flag_in`. If both flags are set, the access is treated as a read and the write is ignored.
- FSM states are IDLE, REQ and DONE.
- **IDLE, op=0:** pass-through. `data_out=data_in`, `reg_write_en_out=reg_write_en_in`, `stall_mem=0`, remain in IDLE.
- **IDLE, op=1:** `stall_mem=1`. Latch `bus_addr`, `bus_wdata` and `bus_we` (`we = write & ~read`), clear the timeout counter, go to REQ.
- **REQ:**
  - `bus_req=1` and `stall_mem=1`; bus outputs are held stable.
  - `bus_ack=1`: capture `bus_rdata` into `rdata_q` and go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT (TIMEOUT≠0), go to DONE with the abort flag set and `rdata_q=0`.
- **DONE:**
  - `stall_mem=0` and `bus_req=0`.
  - `data_out = read ? rdata_q : data_in`.
  - `reg_write_en_out = reg_write_en_in & ~abort`.
  - `bus_timeout=abort`.
  - Unconditionally go to IDLE.
- `reg_addr_out=reg_addr_in` in every state.
- `bus_ack` is ignored outside REQ.
- A store that completes normally does not touch `rdata_q`.

## Timing

- Reset, asynchronous on falling `rst`:
  - state=IDLE; `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_timeout`, `rdata_q`, counter and abort all 0.
  - `stall_mem` is forced to 0 while `rst` is low.
- Reset mid-REQ drops `bus_req` immediately and does not wait for an ack. A late ack after reset is ignored.
- Non-memory instruction: 0 added cycles.
- Memory instruction: 1 (IDLE) + k (REQ, with ack in the k-th REQ cycle, k≥1) + 1 (DONE) cycles. Minimum 3; `stall_mem` is high for k+1 cycles.
- The EX/MEM inputs stay stable while `stall_mem=1`. MEM/WB captures the outputs at the end of DONE.
- Back-to-back memory ops: the next op is seen in the IDLE cycle right after DONE. There are no bubble cycles beyond this.
- Ack in the same cycle the counter hits TIMEOUT: the ack wins and there is no abort.

## Test plan

- ALU op with `data_in=0x1234`, `reg_write_en_in=1`, `reg_addr_in=5` -> same cycle: `data_out=0x1234`, `reg_write_en_out=1`, `stall_mem=0`, `bus_req` never rises.
- Load at `0x100` with ack after 2 REQ cycles and `rdata=0xCAFEF00D` -> `bus_addr=0x100`, `bus_we=0`, `stall_mem` high 3 cycles, `data_out=0xCAFEF00D` in DONE.
- Store of `0xA5A5A5A5` at `0x203` -> `bus_addr=0x200`, `bus_we=1`, `bus_wdata=0xA5A5A5A5`; ack in the 1st REQ cycle gives a total of 3 cycles.
- TIMEOUT=4, load with no ack -> 4 REQ cycles, then DONE: `bus_timeout=1` for 1 cycle, `reg_write_en_out=0`, `data_out=0`.
- Both flags set, then a stray ack in IDLE -> `bus_we=0`; the stray ack is ignored and the state stays IDLE.
- `rst` low in the 2nd REQ cycle -> `bus_req=0` and `stall_mem=0` immediately; after release, state=IDLE and a new load completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the MEM-stage access unit and data memory.
// master: drives bus_req/bus_we/bus_addr/bus_wdata/bus_timeout; slave: returns bus_rdata/bus_ack.
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              bus_timeout;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_timeout,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_timeout,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns loads/stores into req/ack bus transactions.
// Ports: clk, rst (async active-low), EX/MEM fields in, MEM/WB fields + stall_mem out, bus (master).
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              reg_write_en_in,
    input  logic [REG_W-1:0]  reg_addr_in,
    input  logic              mem_read_flag_in,
    input  logic              mem_write_flag_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_write_data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              reg_write_en_out,
    output logic [REG_W-1:0]  reg_addr_out,
    output logic              stall_mem,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              bus_timeout_q, bus_timeout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              abort_q, abort_d;

    logic              op;
    logic [7:0]        cnt_inc;
    logic              to_hit;
    logic              unused_addr_lsb;

    assign op      = mem_read_flag_in | mem_write_flag_in;
    assign cnt_inc = cnt_q + 8'd1;
    // Limit reached on this REQ cycle; an ack in the same cycle takes priority.
    assign to_hit  = (TO_LIM != 8'd0) && (cnt_inc == TO_LIM);

    assign unused_addr_lsb = ^mem_addr_in[1:0];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_timeout_q <= 1'b0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_timeout_q <= bus_timeout_d;
            rdata_q       <= rdata_d;
            cnt_q         <= cnt_d;
            abort_q       <= abort_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (op) state_d = REQ;
            REQ: begin
                if (bus.bus_ack)  state_d = DONE;
                else if (to_hit)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered datapath / bus next values
    always_comb begin
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        abort_d       = abort_q;
        bus_timeout_d = 1'b0;
        // bus_req is high exactly while the FSM sits in REQ.
        bus_req_d     = (state_d == REQ);
        case (state_q)
            IDLE: begin
                if (op) begin
                    bus_we_d    = mem_write_flag_in & ~mem_read_flag_in;
                    bus_addr_d  = {mem_addr_in[ADDR_W-1:2], 2'b00};
                    bus_wdata_d = mem_write_data_in;
                    cnt_d       = '0;
                    abort_d     = 1'b0;
                end
            end
            REQ: begin
                if (bus.bus_ack) begin
                    // Stores leave the last load result untouched.
                    if (mem_read_flag_in) rdata_d = bus.bus_rdata;
                end else begin
                    cnt_d = cnt_inc;
                    if (to_hit) begin
                        abort_d       = 1'b1;
                        rdata_d       = '0;
                        bus_timeout_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        data_out         = data_in;
        reg_write_en_out = reg_write_en_in;
        stall_mem        = 1'b0;
        case (state_q)
            IDLE: stall_mem = op;
            REQ:  stall_mem = 1'b1;
            DONE: begin
                data_out         = mem_read_flag_in ? rdata_q : data_in;
                reg_write_en_out = reg_write_en_in & ~abort_q;
            end
            default: ;
        endcase
        if (!rst) stall_mem = 1'b0;
    end

    assign reg_addr_out    = reg_addr_in;
    assign bus.bus_req     = bus_req_q;
    assign bus.bus_we      = bus_we_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wdata   = bus_wdata_q;
    assign bus.bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (TIMEOUT=4).
// Each task drives one scenario and checks results inline against hand-computed values.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_addr_in;
    logic        mem_read_flag_in;
    logic        mem_write_flag_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_write_data_in;
    logic [31:0] data_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_addr_out;
    logic        stall_mem;

    int vecs = 0;
    int errs = 0;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus_if ();

    mem_access_unit #(
        .DATA_W(32), .ADDR_W(32), .REG_W(5), .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .reg_write_en_in(reg_write_en_in),
        .reg_addr_in(reg_addr_in),
        .mem_read_flag_in(mem_read_flag_in),
        .mem_write_flag_in(mem_write_flag_in),
        .mem_addr_in(mem_addr_in),
        .mem_write_data_in(mem_write_data_in),
        .data_out(data_out),
        .reg_write_en_out(reg_write_en_out),
        .reg_addr_out(reg_addr_out),
        .stall_mem(stall_mem),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        data_in           = 32'h0;
        reg_write_en_in   = 1'b0;
        reg_addr_in       = 5'd0;
        mem_read_flag_in  = 1'b0;
        mem_write_flag_in = 1'b0;
        mem_addr_in       = 32'h0;
        mem_write_data_in = 32'h0;
    endtask

    // Drives one memory op starting in IDLE; ack_at=0 means never ack.
    // Returns observations; caller is left in the IDLE cycle after DONE.
    task automatic do_op(
        input  logic        rd,
        input  logic        wr,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] din,
        input  logic        we_in,
        input  int          ack_at,
        input  logic [31:0] rdata,
        output int          stall_cyc,
        output int          req_cyc,
        output logic [31:0] o_addr,
        output logic [31:0] o_wdata,
        output logic        o_we,
        output logic [31:0] o_data,
        output logic        o_rwe,
        output logic        o_to,
        output logic        finished
    );
        mem_read_flag_in  = rd;
        mem_write_flag_in = wr;
        mem_addr_in       = addr;
        mem_write_data_in = wdata;
        data_in           = din;
        reg_write_en_in   = we_in;
        reg_addr_in       = 5'd9;
        stall_cyc = 0;
        req_cyc   = 0;
        finished  = 1'b0;
        o_addr = '0; o_wdata = '0; o_we = 1'b0;
        o_data = '0; o_rwe = 1'b0; o_to = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            if (bus_if.bus_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    o_addr  = bus_if.bus_addr;
                    o_wdata = bus_if.bus_wdata;
                    o_we    = bus_if.bus_we;
                end
                if (req_cyc == ack_at) begin
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_rdata = rdata;
                end
            end
            if (stall_mem) begin
                stall_cyc++;
            end else begin
                finished = 1'b1;
                o_data   = data_out;
                o_rwe    = reg_write_en_out;
                o_to     = bus_if.bus_timeout;
            end
            next_cycle();
            bus_if.bus_ack   = 1'b0;
            bus_if.bus_rdata = 32'hDEAD_0000;
        end
        set_nop();
        if (!finished) begin
            errs++;
            $display("FAIL op_budget: no DONE within 40 cycles, got stall_cyc=%0d need finish", stall_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_nop();
        mem_read_flag_in = 1'b1;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        #2;
        vecs++;
        if (stall_mem !== 1'b0) begin
            errs++; $display("FAIL reset_stall: got %b need 0", stall_mem);
        end
        vecs++;
        if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_timeout} !== 3'b000) begin
            errs++; $display("FAIL reset_bus_ctl: got %b need 000",
                {bus_if.bus_req, bus_if.bus_we, bus_if.bus_timeout});
        end
        vecs++;
        if ({bus_if.bus_addr, bus_if.bus_wdata} !== 64'h0) begin
            errs++; $display("FAIL reset_bus_data: got %h/%h need 0/0",
                bus_if.bus_addr, bus_if.bus_wdata);
        end
        set_nop();
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_alu_pass();
        data_in         = 32'h1234;
        reg_write_en_in = 1'b1;
        reg_addr_in     = 5'd5;
        #1;
        vecs++;
        if ({data_out, reg_write_en_out, reg_addr_out, stall_mem} !==
            {32'h1234, 1'b1, 5'd5, 1'b0}) begin
            errs++; $display("FAIL alu_pass: got %h/%b/%0d/%b need 1234/1/5/0",
                data_out, reg_write_en_out, reg_addr_out, stall_mem);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            vecs++;
            if (bus_if.bus_req !== 1'b0 || stall_mem !== 1'b0) begin
                errs++; $display("FAIL alu_no_req: got req=%b stall=%b need 0/0",
                    bus_if.bus_req, stall_mem);
            end
        end
        set_nop();
    endtask

    task automatic test_load();
        int sc, rc;
        logic [31:0] a, wd, d;
        logic w, rwe, to, fin;
        do_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h5A5A, 1'b1, 2, 32'hCAFEF00D,
              sc, rc, a, wd, w, d, rwe, to, fin);
        vecs++;
        if (sc != 3 || rc != 2) begin
            errs++; $display("FAIL load_cycles: got stall=%0d req=%0d need 3/2", sc, rc);
        end
        vecs++;
        if (a !== 32'h100 || w !== 1'b0) begin
            errs++; $display("FAIL load_bus: got addr=%h we=%b need 100/0", a, w);
        end
        vecs++;
        if (d !== 32'hCAFEF00D || rwe !== 1'b1 || to !== 1'b0) begin
            errs++; $display("FAIL load_done: got %h/%b/%b need cafef00d/1/0", d, rwe, to);
        end
    endtask

    task automatic test_store();
        int sc, rc;
        logic [31:0] a, wd, d;
        logic w, rwe, to, fin;
        do_op(1'b0, 1'b1, 32'h203, 32'hA5A5A5A5, 32'h77, 1'b0, 1, 32'h1111_2222,
              sc, rc, a, wd, w, d, rwe, to, fin);
        vecs++;
        if (sc != 2 || rc != 1) begin
            errs++; $display("FAIL store_cycles: got stall=%0d req=%0d need 2/1", sc, rc);
        end
        vecs++;
        if (a !== 32'h200 || w !== 1'b1 || wd !== 32'hA5A5A5A5) begin
            errs++; $display("FAIL store_bus: got %h/%b/%h need 200/1/a5a5a5a5", a, w, wd);
        end
        vecs++;
        if (d !== 32'h77 || rwe !== 1'b0 || to !== 1'b0) begin
            errs++; $display("FAIL store_done: got %h/%b/%b need 77/0/0", d, rwe, to);
        end
    endtask

    task automatic test_timeout();
        int sc, rc;
        logic [31:0] a, wd, d;
        logic w, rwe, to, fin;
        do_op(1'b1, 1'b0, 32'h40, 32'h0, 32'h99, 1'b1, 0, 32'h0,
              sc, rc, a, wd, w, d, rwe, to, fin);
        vecs++;
        if (sc != 5 || rc != 4) begin
            errs++; $display("FAIL timeout_cycles: got stall=%0d req=%0d need 5/4", sc, rc);
        end
        vecs++;
        if (to !== 1'b1 || rwe !== 1'b0 || d !== 32'h0) begin
            errs++; $display("FAIL timeout_done: got to=%b rwe=%b data=%h need 1/0/0", to, rwe, d);
        end
        vecs++;
        if (bus_if.bus_timeout !== 1'b0) begin
            errs++; $display("FAIL timeout_pulse: got %b need 0 after DONE", bus_if.bus_timeout);
        end
    endtask

    task automatic test_ack_at_limit();
        int sc, rc;
        logic [31:0] a, wd, d;
        logic w, rwe, to, fin;
        do_op(1'b1, 1'b0, 32'h48, 32'h0, 32'h0, 1'b1, 4, 32'h600D_0004,
              sc, rc, a, wd, w, d, rwe, to, fin);
        vecs++;
        if (rc != 4 || to !== 1'b0 || rwe !== 1'b1 || d !== 32'h600D0004) begin
            errs++; $display("FAIL ack_at_limit: got req=%0d to=%b rwe=%b data=%h need 4/0/1/600d0004",
                rc, to, rwe, d);
        end
    endtask

    task automatic test_both_flags_stray_ack();
        int sc, rc;
        logic [31:0] a, wd, d;
        logic w, rwe, to, fin;
        do_op(1'b1, 1'b1, 32'h7C, 32'hFFFF_0000, 32'h0, 1'b1, 1, 32'h0BADBEEF,
              sc, rc, a, wd, w, d, rwe, to, fin);
        vecs++;
        if (w !== 1'b0 || d !== 32'h0BADBEEF) begin
            errs++; $display("FAIL both_flags: got we=%b data=%h need 0/0badbeef", w, d);
        end
        data_in          = 32'h3333;
        reg_write_en_in  = 1'b1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hEEEE_EEEE;
        next_cycle();
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus_if.bus_req !== 1'b0 || stall_mem !== 1'b0 ||
            data_out !== 32'h3333 || reg_write_en_out !== 1'b1) begin
            errs++; $display("FAIL stray_ack: got req=%b stall=%b data=%h rwe=%b need 0/0/3333/1",
                bus_if.bus_req, stall_mem, data_out, reg_write_en_out);
        end
        next_cycle();
        set_nop();
    endtask

    task automatic test_back_to_back();
        int sc, rc, sc2, rc2;
        logic [31:0] a, wd, d, a2, d2;
        logic w, rwe, to, fin;
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 32'hAAAA_0001,
              sc, rc, a, wd, w, d, rwe, to, fin);
        do_op(1'b1, 1'b0, 32'h14, 32'h0, 32'h0, 1'b1, 1, 32'hAAAA_0002,
              sc2, rc2, a2, wd, w, d2, rwe, to, fin);
        vecs++;
        if (sc != 2 || sc2 != 2 || d !== 32'hAAAA0001 || d2 !== 32'hAAAA0002 || a2 !== 32'h14) begin
            errs++; $display("FAIL back_to_back: got %0d/%0d %h/%h a2=%h need 2/2 aaaa0001/aaaa0002 14",
                sc, sc2, d, d2, a2);
        end
    endtask

    task automatic test_reset_mid_req();
        int sc, rc;
        logic [31:0] a, wd, d;
        logic w, rwe, to, fin;
        mem_read_flag_in = 1'b1;
        mem_addr_in      = 32'h300;
        reg_write_en_in  = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        vecs++;
        if (bus_if.bus_req !== 1'b0 || stall_mem !== 1'b0 || bus_if.bus_addr !== 32'h0) begin
            errs++; $display("FAIL reset_mid_req: got req=%b stall=%b addr=%h need 0/0/0",
                bus_if.bus_req, stall_mem, bus_if.bus_addr);
        end
        next_cycle();
        set_nop();
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h5151_5151;
        #2;
        rst = 1'b1;
        next_cycle();
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus_if.bus_req !== 1'b0 || stall_mem !== 1'b0) begin
            errs++; $display("FAIL late_ack: got req=%b stall=%b need 0/0", bus_if.bus_req, stall_mem);
        end
        next_cycle();
        do_op(1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 1'b1, 1, 32'h5555_1234,
              sc, rc, a, wd, w, d, rwe, to, fin);
        vecs++;
        if (sc != 2 || a !== 32'h44 || d !== 32'h55551234 || rwe !== 1'b1) begin
            errs++; $display("FAIL after_reset_load: got stall=%0d addr=%h data=%h rwe=%b need 2/44/55551234/1",
                sc, a, d, rwe);
        end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load();
        test_store();
        test_timeout();
        test_ack_at_limit();
        test_both_flags_stray_ack();
        test_back_to_back();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
